// File: rtl/cpu_pkg.sv
// Shared loader definitions: word geometry, frame sync byte
// and the loader FSM state encoding.
package cpu_pkg;

   localparam int WORD_SIZE = 32;
   localparam int BYTES_PER_WORD = WORD_SIZE / 8;
   localparam logic [7:0] LOADER_SYNC = 8'hA5;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_LEN0  = 3'd1,
      ST_LEN1  = 3'd2,
      ST_DATA  = 3'd3,
      ST_CSUM  = 3'd4,
      ST_DONE  = 3'd5,
      ST_ERROR = 3'd6
   } loader_state_e;

endpackage

// File: rtl/imem_loader_if.sv
// Loader bus: byte stream in (rx_*) and imem write port out (imem_*).
// master = stream source / memory side, slave = the loader.
interface imem_loader_if #(
   parameter int AW = 10,
   parameter int WW = 32
);
   logic [7:0]    rx_data;
   logic          rx_valid;
   logic          rx_ready;
   logic          imem_we;
   logic [AW-1:0] imem_addr;
   logic [WW-1:0] imem_wdata;
   logic          imem_ready;

   modport master (
      output rx_data, rx_valid, imem_ready,
      input  rx_ready, imem_we, imem_addr, imem_wdata
   );

   modport slave (
      input  rx_data, rx_valid, imem_ready,
      output rx_ready, imem_we, imem_addr, imem_wdata
   );
endinterface

// File: rtl/loader_word_assembler.sv
// Packs accepted bytes little-endian into a word; word_done_o pulses
// with the last byte. Ports: clk, rst (async low), clr_i, valid_i, byte_i.
module loader_word_assembler
   import cpu_pkg::*;
(
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 clr_i,
   input  logic                 valid_i,
   input  logic [7:0]           byte_i,
   output logic [WORD_SIZE-1:0] word_o,
   output logic                 word_done_o
);
   localparam int IW = $clog2(BYTES_PER_WORD);
   localparam logic [IW-1:0] LAST = IW'(BYTES_PER_WORD - 1);
   localparam logic [IW-1:0] ONE = IW'(1);

   logic [IW-1:0]        idx_q, idx_d;
   logic [WORD_SIZE-1:0] word_q;

   // word_o already carries the incoming byte so the
   // completed word is usable in the same cycle
   always_comb begin
      word_o = word_q;
      word_o[8*idx_q +: 8] = byte_i;
      idx_d = idx_q + ONE;
      word_done_o = valid_i && (idx_q == LAST);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         idx_q  <= '0;
         word_q <= '0;
      end else if (clr_i) begin
         idx_q  <= '0;
         word_q <= '0;
      end else if (valid_i) begin
         idx_q  <= idx_d;
         word_q <= word_o;
      end
   end
endmodule

// File: rtl/imem_loader.sv
// Boot loader: framed byte stream -> imem writes, releases core on good csum.
// Ports: clk, rst (async low), bus (slave), core_run, load_err, words_loaded.
module imem_loader
   import cpu_pkg::*;
#(
   parameter int ADDR_SIZE = 10
) (
   input  logic                 clk,
   input  logic                 rst,
   imem_loader_if.slave         bus,
   output logic                 core_run,
   output logic                 load_err,
   output logic [ADDR_SIZE:0]   words_loaded
);
   localparam logic [16:0] MAX_CNT = 17'(2 ** ADDR_SIZE);
   localparam logic [ADDR_SIZE-1:0] A_ONE = ADDR_SIZE'(1);
   localparam logic [ADDR_SIZE:0] W_ONE = (ADDR_SIZE + 1)'(1);

   loader_state_e        state_q, state_d;
   logic [15:0]          cnt_q, cnt_d;
   logic [ADDR_SIZE-1:0] addr_q, addr_d;
   logic [ADDR_SIZE:0]   words_q, words_d;
   logic [7:0]           csum_q, csum_d;
   logic                 we_q, we_d;
   logic [WORD_SIZE-1:0] wdata_q, wdata_d;
   logic                 run_q, run_d;
   logic                 err_q, err_d;

   logic                 fire;
   logic                 is_sync;
   logic [15:0]          cnt_full;
   logic                 len_ok;
   logic                 last_word;
   logic                 asm_clr;
   logic                 asm_valid;
   logic [WORD_SIZE-1:0] asm_word;
   logic                 asm_done;

   assign bus.rx_ready   = ~we_q;
   assign bus.imem_we    = we_q;
   assign bus.imem_addr  = addr_q;
   assign bus.imem_wdata = wdata_q;
   assign core_run       = run_q;
   assign load_err       = err_q;
   assign words_loaded   = words_q;

   assign fire      = bus.rx_valid & ~we_q;
   assign is_sync   = bus.rx_data == LOADER_SYNC;
   assign cnt_full  = {bus.rx_data, cnt_q[7:0]};
   assign len_ok    = (cnt_full != 16'd0) && ({1'b0, cnt_full} <= MAX_CNT);
   assign last_word = (16'(words_q) + 16'd1) == cnt_q;
   assign asm_valid = fire && (state_q == ST_DATA);

   loader_word_assembler u_asm (
      .clk         (clk),
      .rst         (rst),
      .clr_i       (asm_clr),
      .valid_i     (asm_valid),
      .byte_i      (bus.rx_data),
      .word_o      (asm_word),
      .word_done_o (asm_done)
   );

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      addr_d  = addr_q;
      words_d = words_q;
      csum_d  = csum_q;
      we_d    = we_q;
      wdata_d = wdata_q;
      run_d   = run_q;
      err_d   = err_q;
      asm_clr = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            if (fire && is_sync) state_d = ST_LEN0;
         end
         ST_LEN0: begin
            if (fire) begin
               cnt_d[7:0] = bus.rx_data;
               state_d = ST_LEN1;
            end
         end
         ST_LEN1: begin
            if (fire) begin
               cnt_d[15:8] = bus.rx_data;
               if (len_ok) begin
                  addr_d  = '0;
                  words_d = '0;
                  csum_d  = '0;
                  asm_clr = 1'b1;
                  state_d = ST_DATA;
               end else begin
                  err_d   = 1'b1;
                  state_d = ST_ERROR;
               end
            end
         end
         ST_DATA: begin
            if (fire) csum_d = csum_q ^ bus.rx_data;
            if (asm_done) begin
               we_d    = 1'b1;
               wdata_d = asm_word;
            end
            if (we_q && bus.imem_ready) begin
               we_d    = 1'b0;
               addr_d  = addr_q + A_ONE;
               words_d = words_q + W_ONE;
               if (last_word) state_d = ST_CSUM;
            end
         end
         ST_CSUM: begin
            if (fire) begin
               if (bus.rx_data == csum_q) begin
                  run_d   = 1'b1;
                  err_d   = 1'b0;
                  state_d = ST_DONE;
               end else begin
                  run_d   = 1'b0;
                  err_d   = 1'b1;
                  state_d = ST_ERROR;
               end
            end
         end
         ST_DONE: begin
            if (fire && is_sync) begin
               run_d   = 1'b0;
               state_d = ST_LEN0;
            end
         end
         ST_ERROR: begin
            if (fire && is_sync) begin
               err_d   = 1'b0;
               state_d = ST_LEN0;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         addr_q  <= '0;
         words_q <= '0;
         csum_q  <= '0;
         we_q    <= 1'b0;
         wdata_q <= '0;
         run_q   <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         addr_q  <= addr_d;
         words_q <= words_d;
         csum_q  <= csum_d;
         we_q    <= we_d;
         wdata_q <= wdata_d;
         run_q   <= run_d;
         err_q   <= err_d;
      end
   end
endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: frames built from word lists,
// expected writes queued at stimulus time, checked by a write monitor.
module tb_imem_loader;
   import cpu_pkg::*;

   localparam int AW = 10;

   typedef struct packed {
      logic [AW-1:0] addr;
      logic [31:0]   data;
   } wr_t;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          core_run;
   logic          load_err;
   logic [AW:0]   words_loaded;

   imem_loader_if #(.AW(AW), .WW(WORD_SIZE)) bus ();

   imem_loader #(.ADDR_SIZE(AW)) dut (
      .clk          (clk),
      .rst          (rst),
      .bus          (bus),
      .core_run     (core_run),
      .load_err     (load_err),
      .words_loaded (words_loaded)
   );

   always #5 clk = ~clk;

   int          tests = 0;
   int          fails = 0;
   int          writes_seen = 0;
   int          rdy_mode = 0;
   wr_t         exp_q[$];
   logic [31:0] frame_w[$];
   logic [7:0]  fbytes[$];
   bit          e_run = 1'b0;
   bit          e_err = 1'b0;
   int          e_words = 0;
   int          e_writes = 0;

   function automatic void chk(input string nm, input logic [63:0] act,
                               input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endfunction

   // write monitor: a write is taken on the edge after a
   // negedge where imem_we and imem_ready are both high
   always @(negedge clk) begin
      if (rst && bus.imem_we && bus.imem_ready) begin
         writes_seen++;
         if (exp_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_write: addr %0h data %0h expected none",
                     bus.imem_addr, bus.imem_wdata);
         end else begin
            wr_t e;
            e = exp_q.pop_front();
            chk("wr_addr", 64'(bus.imem_addr), 64'(e.addr));
            chk("wr_data", 64'(bus.imem_wdata), 64'(e.data));
         end
      end
   end

   initial begin
      bus.imem_ready = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         case (rdy_mode)
            0: bus.imem_ready = 1'b1;
            1: bus.imem_ready = 1'($urandom_range(0, 1));
            default: bus.imem_ready = 1'b0;
         endcase
      end
   end

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // reference: frame bytes, expected writes and end status
   function automatic void build(input logic [15:0] cnt, input bit bad);
      logic [7:0] cs;
      bit ok;
      cs = 8'h00;
      ok = (cnt != 16'd0) && (int'(cnt) <= (1 << AW));
      fbytes.delete();
      fbytes.push_back(8'hA5);
      fbytes.push_back(cnt[7:0]);
      fbytes.push_back(cnt[15:8]);
      if (ok) begin
         for (int i = 0; i < int'(cnt); i++) begin
            for (int b = 0; b < 4; b++) begin
               fbytes.push_back(frame_w[i][8*b +: 8]);
               cs ^= frame_w[i][8*b +: 8];
            end
            exp_q.push_back(wr_t'{addr: AW'(i), data: frame_w[i]});
         end
         fbytes.push_back(bad ? (cs ^ 8'h01) : cs);
         e_words  = int'(cnt);
         e_run    = !bad;
         e_err    = bad;
         e_writes = int'(cnt);
      end else begin
         e_run    = 1'b0;
         e_err    = 1'b1;
         e_writes = 0;
      end
   endfunction

   function automatic void fill_random(input int n);
      frame_w.delete();
      for (int i = 0; i < n; i++) frame_w.push_back($urandom);
   endfunction

   function automatic void fill_nominal();
      frame_w.delete();
      frame_w.push_back(32'h0000_0013);
      frame_w.push_back(32'h0010_0093);
   endfunction

   task automatic send_byte(input logic [7:0] b);
      bus.rx_data  = b;
      bus.rx_valid = 1'b1;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (bus.rx_ready) begin
            @(posedge clk);
            #1;
            bus.rx_valid = 1'b0;
            return;
         end
      end
      bus.rx_valid = 1'b0;
      tests++;
      fails++;
      $display("FAIL rx_timeout: rx_ready 0 for 200 cycles, required 1");
   endtask

   task automatic send_range(input int from, input int to, input bit gaps);
      for (int i = from; i < to; i++) begin
         if (gaps && $urandom_range(0, 7) == 0) begin
            @(posedge clk);
            #1;
         end
         send_byte(fbytes[i]);
      end
   endtask

   task automatic check_status(input string nm, input int ws0);
      chk({nm, "_core_run"}, 64'(core_run), 64'(e_run));
      chk({nm, "_load_err"}, 64'(load_err), 64'(e_err));
      chk({nm, "_words"}, 64'(words_loaded), 64'(e_words));
      chk({nm, "_pending"}, 64'(exp_q.size()), 64'd0);
      chk({nm, "_nwrites"}, 64'(writes_seen - ws0), 64'(e_writes));
   endtask

   task automatic do_frame(input string nm, input logic [15:0] cnt,
                           input bit bad, input bit gaps);
      int ws0;
      ws0 = writes_seen;
      build(cnt, bad);
      send_range(0, fbytes.size(), gaps);
      check_status(nm, ws0);
   endtask

   task automatic check_reset(input string nm);
      chk({nm, "_rx_ready"}, 64'(bus.rx_ready), 64'd1);
      chk({nm, "_we"}, 64'(bus.imem_we), 64'd0);
      chk({nm, "_addr"}, 64'(bus.imem_addr), 64'd0);
      chk({nm, "_wdata"}, 64'(bus.imem_wdata), 64'd0);
      chk({nm, "_core_run"}, 64'(core_run), 64'd0);
      chk({nm, "_load_err"}, 64'(load_err), 64'd0);
      chk({nm, "_words"}, 64'(words_loaded), 64'd0);
   endtask

   initial begin
      int ws0;
      logic [7:0] g;
      bus.rx_data  = 8'h00;
      bus.rx_valid = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_reset("reset");
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;

      fill_nominal();
      do_frame("nominal", 16'd2, 1'b0, 1'b0);
      do_frame("bad_csum", 16'd2, 1'b1, 1'b0);
      do_frame("recover", 16'd2, 1'b0, 1'b0);

      // write port held off for 5 cycles on the first word,
      // with the next byte offered the whole time
      fill_nominal();
      build(16'd2, 1'b0);
      ws0 = writes_seen;
      rdy_mode = 2;
      repeat (2) @(posedge clk);
      #1;
      send_range(0, 7, 1'b0);
      bus.rx_data  = fbytes[7];
      bus.rx_valid = 1'b1;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         chk("bp_we", 64'(bus.imem_we), 64'd1);
         chk("bp_addr", 64'(bus.imem_addr), 64'd0);
         chk("bp_wdata", 64'(bus.imem_wdata), 64'h13);
         chk("bp_rx_ready", 64'(bus.rx_ready), 64'd0);
      end
      rdy_mode = 0;
      send_range(7, fbytes.size(), 1'b0);
      check_status("backpressure", ws0);

      do_frame("len_zero", 16'h0000, 1'b0, 1'b0);
      do_frame("len_over", 16'h0401, 1'b0, 1'b0);
      rdy_mode = 1;
      fill_random(1024);
      do_frame("len_max", 16'h0400, 1'b0, 1'b0);
      rdy_mode = 0;

      // asynchronous reset after 6 data bytes
      fill_nominal();
      build(16'd2, 1'b0);
      send_range(0, 9, 1'b0);
      #3;
      rst = 1'b0;
      #1;
      check_reset("mid_reset");
      chk("mid_reset_written", 64'(exp_q.size()), 64'd1);
      exp_q.delete();
      e_words = 0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk);
      #1;

      send_byte(8'h00);
      send_byte(8'hFF);
      send_byte(8'h12);
      chk("garbage_words", 64'(words_loaded), 64'd0);
      fill_nominal();
      do_frame("after_garbage", 16'd2, 1'b0, 1'b0);

      rdy_mode = 1;
      for (int f = 0; f < 6; f++) begin
         repeat ($urandom_range(0, 3)) begin
            g = 8'($urandom_range(0, 255));
            if (g == 8'hA5) g = 8'h5A;
            send_byte(g);
         end
         fill_random(int'($urandom_range(1, 12)));
         do_frame("random", 16'(frame_w.size()),
                  $urandom_range(0, 2) == 0, 1'b1);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
